cmd_responder: RTL and testbench
================================

# cmd_responder

Terminating responder for the cmd/adr/data transaction stream leaving the dut master port. It decodes each cycle's command, maintains a small register file (plain write, accumulate-write, read with registered response), and tracks which addresses have been written (unique-address coverage), so a bench or embedded checker can see when the address space is exhausted. It sits on the far end of `dut_if`, opposite the stimulus driver on the slave side.

## Interface
- `ADR_W`, 4, address width; register file depth is 2**ADR_W.
- `DATA_W`, 8, data width of register entries, the request and the response.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on rising edge of `clk`.
- `cmd` input 2: command, sampled every cycle; encoding is t_cmd (0 NOP, 1 READ, 2 WRITE, 3 ACC).
- `adr` input ADR_W: target address.
- `data` input DATA_W: write/accumulate operand; ignored for NOP/READ.
- `clr_cov` input 1: clears the coverage map and count.
- `rsp_valid` output 1: read response valid.
- `rsp_adr` output ADR_W: address of the read being answered.
- `rsp_data` output DATA_W: read data.
- `cov_map` output 2**ADR_W: bit i set once address i has been written (WRITE or ACC).
- `cov_count` output ADR_W+1: population count of `cov_map`.
- `cov_done` output 1: high when `cov_count` == 2**ADR_W.

## Operation
- No handshake: one command per cycle, always accepted; NOP (0) changes nothing.
- WRITE (2): mem[adr] <= data.
- ACC (3): mem[adr] <= mem[adr] + data, modulo 2**DATA_W (carry discarded, wraps).
- READ (1): captures mem[adr]; response presented next cycle (see Timing). Contents unchanged.
- WRITE/ACC set `cov_map[adr]`; `cov_count` increments only if that bit was previously clear (repeat writes do not count).
- `clr_cov` with a WRITE/ACC in the same cycle: clear applies first, then the current address is recorded; result is `cov_map` with only bit adr set, `cov_count` = 1.
- `clr_cov` never affects register contents or responses.
- `cov_done` is sticky only as long as the map is full; it drops on `clr_cov`.
- Reset: all mem entries 0, `rsp_valid` 0, `rsp_adr` 0, `rsp_data` 0, `cov_map` 0, `cov_count` 0, `cov_done` 0. Command in the reset cycle is discarded.
- Reset asserted while a read response is pending: response is dropped, `rsp_valid` is 0 the cycle after reset.

## Timing
- Command sampled at rising edge N; register write and coverage update visible after edge N.
- READ sampled at edge N: `rsp_valid`=1, `rsp_adr`, `rsp_data` valid after edge N, for exactly one cycle (until edge N+1). Latency 1.
- Back-to-back READs produce back-to-back responses; `rsp_valid` stays high.
- READ at edge N+1 of an address written/accumulated at edge N returns the updated value (no stale read).
- Non-READ cycles: `rsp_valid`=0; `rsp_adr`/`rsp_data` hold last values.
- `cov_count`/`cov_done` are registered, updated same edge as `cov_map`; no combinational input-to-output paths.

## Structure
- covemb_pkg: t_cmd enum (CMD_NOP, CMD_READ, CMD_WRITE, CMD_ACC), default widths as localparams.
- Sub-module cov_tracker: takes write strobe, address, `clr_cov`; owns `cov_map`, `cov_count`, `cov_done`. cmd_responder owns decode, register file, response register.

## Test plan
- Reset, then WRITE adr 5 data 0x2A, READ adr 5 -> next cycle `rsp_valid`=1, `rsp_adr`=5, `rsp_data`=0x2A; `cov_count`=1, `cov_map`=0x0020.
- WRITE adr 7 0xF0, ACC adr 7 0x20, READ adr 7 -> `rsp_data`=0x10 (wrap); `cov_count` stays 1 for adr 7.
- WRITE adr 9 at edge N, READ adr 9 at N+1 -> updated value returned; three consecutive READs -> `rsp_valid` high three cycles.
- WRITE all addresses 0..15 in random order with repeats -> `cov_count`=16 and `cov_done`=1 only after last new address.
- `clr_cov` with WRITE adr 3 in same cycle -> `cov_map`=0x0008, `cov_count`=1, `cov_done`=0; memory unchanged elsewhere.
- READ at edge N with `rst_n`=0 at edge N+1 -> `rsp_valid`=0, all outputs and mem back to 0.

Source files
------------

// File: rtl/covemb_pkg.sv
// Shared types and default widths for the cmd/adr/data responder.
package covemb_pkg;

    // Command encoding on the cmd bus, sampled every cycle.
    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_ACC   = 2'd3
    } t_cmd;

    localparam int ADR_W_DEF  = 4;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/cov_tracker.sv
// Unique-address write coverage: map of written addresses, its population
// count, and a full flag. clr_cov takes effect before the current write.
module cov_tracker #(
    parameter int ADR_W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [ADR_W-1:0]        wr_adr,
    input  logic                    clr_cov,
    output logic [(1<<ADR_W)-1:0]   cov_map,
    output logic [ADR_W:0]          cov_count,
    output logic                    cov_done
);

    localparam int DEPTH = 1 << ADR_W;
    localparam logic [ADR_W:0] FULL = (ADR_W+1)'(DEPTH);

    logic [DEPTH-1:0] map_base;
    logic [ADR_W:0]   count_base;
    logic [DEPTH-1:0] map_next;
    logic [ADR_W:0]   count_next;

    // Next-state coverage: clear first, then record a new address once.
    always_comb begin
        map_base   = clr_cov ? '0 : cov_map;
        count_base = clr_cov ? '0 : cov_count;
        map_next   = map_base;
        count_next = count_base;
        if (wr_en) begin
            map_next   = map_base | (DEPTH'(1) << wr_adr);
            count_next = count_base + {{ADR_W{1'b0}}, ~map_base[wr_adr]};
        end
    end

    // Register map, count and done together so they never disagree.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cov_map   <= '0;
            cov_count <= '0;
            cov_done  <= 1'b0;
        end else begin
            cov_map   <= map_next;
            cov_count <= count_next;
            cov_done  <= (count_next == FULL);
        end
    end

endmodule

// File: rtl/cmd_responder.sv
// Terminating responder: decodes one command per cycle, holds a small
// register file (write / accumulate / read with one-cycle registered
// response) and reports which addresses have been written.
// There is no handshake: every cycle carries exactly one command, which is
// always accepted; rsp_valid is a one-cycle strobe with no back-pressure.
module cmd_responder
    import covemb_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:0]              cmd,
    input  logic [ADR_W-1:0]        adr,
    input  logic [DATA_W-1:0]       data,
    input  logic                    clr_cov,
    output logic                    rsp_valid,
    output logic [ADR_W-1:0]        rsp_adr,
    output logic [DATA_W-1:0]       rsp_data,
    output logic [(1<<ADR_W)-1:0]   cov_map,
    output logic [ADR_W:0]          cov_count,
    output logic                    cov_done
);

    localparam int DEPTH = 1 << ADR_W;

    t_cmd              cmd_t;
    logic              wr_en;
    logic [DATA_W-1:0] mem [DEPTH];

    assign cmd_t = t_cmd'(cmd);
    assign wr_en = (cmd_t == CMD_WRITE) || (cmd_t == CMD_ACC);

    // Register file updates and the registered read response.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rsp_valid <= 1'b0;
            rsp_adr   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= (cmd_t == CMD_READ);
            case (cmd_t)
                CMD_READ: begin
                    rsp_adr  <= adr;
                    rsp_data <= mem[adr];
                end
                CMD_WRITE: mem[adr] <= data;
                CMD_ACC:   mem[adr] <= mem[adr] + data;
                default:   ;
            endcase
        end
    end

    cov_tracker #(
        .ADR_W (ADR_W)
    ) u_cov (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_adr    (adr),
        .clr_cov   (clr_cov),
        .cov_map   (cov_map),
        .cov_count (cov_count),
        .cov_done  (cov_done)
    );

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_cmd_responder;

    localparam int ADR_W  = 4;
    localparam int DATA_W = 8;

    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] RD  = 2'd1;
    localparam logic [1:0] WR  = 2'd2;
    localparam logic [1:0] ACC = 2'd3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        cmd = NOP;
    logic [ADR_W-1:0]  adr = '0;
    logic [DATA_W-1:0] data = '0;
    logic              clr_cov = 1'b0;
    logic              rsp_valid;
    logic [ADR_W-1:0]  rsp_adr;
    logic [DATA_W-1:0] rsp_data;
    logic [15:0]       cov_map;
    logic [ADR_W:0]    cov_count;
    logic              cov_done;

    int n_vec = 0;
    int n_err = 0;

    // Bench-side expectations for the coverage walk.
    logic [7:0]  exp_mem [16];
    logic [15:0] exp_map;
    int          exp_cnt;

    cmd_responder #(.ADR_W(ADR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd       (cmd),
        .adr       (adr),
        .data      (data),
        .clr_cov   (clr_cov),
        .rsp_valid (rsp_valid),
        .rsp_adr   (rsp_adr),
        .rsp_data  (rsp_data),
        .cov_map   (cov_map),
        .cov_count (cov_count),
        .cov_done  (cov_done)
    );

    always #5 clk = ~clk;

    // Drive one command at the falling edge, then settle past the rising edge.
    task automatic step(input logic [1:0] c, input logic [3:0] a,
                        input logic [7:0] d, input logic clr);
        @(negedge clk);
        cmd     = c;
        adr     = a;
        data    = d;
        clr_cov = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input string tag, input logic [3:0] a,
                             input logic [7:0] d);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_adr"},   32'(rsp_adr),   32'(a));
        check({tag, "_data"},  32'(rsp_data),  32'(d));
    endtask

    initial begin
        logic [3:0] order [15];
        order = '{4'd0, 4'd3, 4'd3, 4'd12, 4'd1, 4'd15, 4'd5, 4'd8,
                  4'd2, 4'd14, 4'd4, 4'd11, 4'd6, 4'd10, 4'd13};

        // Reset, with a WRITE presented during reset that must be discarded.
        rst_n = 1'b0;
        step(NOP, 4'd0, 8'h00, 1'b0);
        step(WR, 4'd4, 8'h99, 1'b0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_adr",   32'(rsp_adr),   32'd0);
        check("rst_data",  32'(rsp_data),  32'd0);
        check("rst_map",   32'(cov_map),   32'd0);
        check("rst_count", 32'(cov_count), 32'd0);
        check("rst_done",  32'(cov_done),  32'd0);
        rst_n = 1'b1;

        // Plain write then read with one-cycle latency.
        step(WR, 4'd5, 8'h2A, 1'b0);
        check("wr5_valid", 32'(rsp_valid), 32'd0);
        check("wr5_count", 32'(cov_count), 32'd1);
        check("wr5_map",   32'(cov_map),   32'h0020);
        step(RD, 4'd5, 8'hFF, 1'b0);
        check_rsp("rd5", 4'd5, 8'h2A);
        step(RD, 4'd4, 8'h00, 1'b0);
        check_rsp("rd4_rst_discard", 4'd4, 8'h00);
        step(NOP, 4'd9, 8'h11, 1'b0);
        check("nop_valid", 32'(rsp_valid), 32'd0);
        check("nop_hold_adr", 32'(rsp_adr), 32'd4);

        // Accumulate wraps modulo 256; repeat write to adr 7 counts once.
        step(WR, 4'd7, 8'hF0, 1'b0);
        step(ACC, 4'd7, 8'h20, 1'b0);
        check("acc7_count", 32'(cov_count), 32'd2);
        check("acc7_map",   32'(cov_map),   32'h00A0);
        step(RD, 4'd7, 8'h00, 1'b0);
        check_rsp("rd7_wrap", 4'd7, 8'h10);

        // Read right after write sees the new value; back-to-back reads.
        step(WR, 4'd9, 8'h33, 1'b0);
        step(RD, 4'd9, 8'h00, 1'b0);
        check_rsp("rd9_fresh", 4'd9, 8'h33);
        step(RD, 4'd5, 8'h00, 1'b0);
        check_rsp("b2b_1", 4'd5, 8'h2A);
        step(RD, 4'd7, 8'h00, 1'b0);
        check_rsp("b2b_2", 4'd7, 8'h10);
        step(RD, 4'd9, 8'h00, 1'b0);
        check_rsp("b2b_3", 4'd9, 8'h33);

        // Fill the address space in scrambled order with repeats.
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
        exp_mem[5] = 8'h2A;
        exp_mem[7] = 8'h10;
        exp_mem[9] = 8'h33;
        exp_map = 16'h02A0;
        exp_cnt = 3;
        for (int i = 0; i < 15; i++) begin
            step(WR, order[i], 8'h40 + 8'(i), 1'b0);
            exp_mem[order[i]] = 8'h40 + 8'(i);
            if (!exp_map[order[i]]) exp_cnt++;
            exp_map[order[i]] = 1'b1;
            check($sformatf("fill%0d_count", i), 32'(cov_count), 32'(exp_cnt));
            check($sformatf("fill%0d_done", i), 32'(cov_done),
                  32'(exp_cnt == 16));
        end
        check("fill_map", 32'(cov_map), 32'hFFFF);
        step(ACC, 4'd7, 8'h01, 1'b0);
        exp_mem[7] = exp_mem[7] + 8'h01;
        check("full_repeat_count", 32'(cov_count), 32'd16);
        check("full_repeat_done",  32'(cov_done),  32'd1);

        // Clear together with a write: only the current address remains.
        step(WR, 4'd3, 8'h77, 1'b1);
        exp_mem[3] = 8'h77;
        check("clr_wr_map",   32'(cov_map),   32'h0008);
        check("clr_wr_count", 32'(cov_count), 32'd1);
        check("clr_wr_done",  32'(cov_done),  32'd0);
        step(RD, 4'd5, 8'h00, 1'b0);
        check_rsp("clr_mem5", 4'd5, exp_mem[5]);
        step(RD, 4'd7, 8'h00, 1'b1);
        check_rsp("clr_mem7", 4'd7, exp_mem[7]);
        check("clr_only_map",   32'(cov_map),   32'h0000);
        check("clr_only_count", 32'(cov_count), 32'd0);
        step(RD, 4'd3, 8'h00, 1'b0);
        check_rsp("clr_mem3", 4'd3, 8'h77);

        // Reset while a response is pending drops it and clears everything.
        rst_n = 1'b0;
        step(WR, 4'd3, 8'h55, 1'b0);
        check("rst2_valid", 32'(rsp_valid), 32'd0);
        check("rst2_adr",   32'(rsp_adr),   32'd0);
        check("rst2_data",  32'(rsp_data),  32'd0);
        check("rst2_map",   32'(cov_map),   32'd0);
        check("rst2_count", 32'(cov_count), 32'd0);
        rst_n = 1'b1;
        step(RD, 4'd3, 8'h00, 1'b0);
        check_rsp("rst2_mem3", 4'd3, 8'h00);
        step(RD, 4'd13, 8'h00, 1'b0);
        check_rsp("rst2_mem13", 4'd13, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
